knn_topk_merger: RTL and testbench

- Consumer of the L2 distance kernel output stream.
- For each query it accepts one beat per leaf visited: LEAF_SIZE candidate distances and patch indices, framed by query_first/query_last.
- Keeps a running sorted list of the K nearest candidates across all beats of the query, then emits that list once per query to the result buffer.
- Fully pipelined: accepts one beat per clock, no backpressure.

---
 rtl/knn_topk_merger.sv | 157 +++++++++++++++
 tb/tb_knn_topk_merger.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_topk_merger.sv
// knn_topk_merger: keeps the K nearest candidates of a query across leaf beats
// and emits the sorted list once per query when its last beat has merged.
module knn_topk_merger #(
    parameter int DIST_WIDTH = 25,
    parameter int IDX_WIDTH = 9,
    parameter int LEAF_SIZE = 8,
    parameter int K = 4,
    parameter int QCNT_WIDTH = 9
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dist_valid,
    input  logic                            query_first_in,
    input  logic                            query_last_in,
    input  logic [LEAF_SIZE*DIST_WIDTH-1:0] cand_dist,
    input  logic [LEAF_SIZE*IDX_WIDTH-1:0]  cand_idx,
    output logic                            result_valid,
    output logic [K*DIST_WIDTH-1:0]         result_dist,
    output logic [K*IDX_WIDTH-1:0]          result_idx,
    output logic [QCNT_WIDTH-1:0]           result_qid,
    output logic                            protocol_err
);
    localparam int DW = DIST_WIDTH;
    localparam int IW = IDX_WIDTH;
    localparam int N = 2 * K;
    logic                      in_valid, in_first, in_last;
    logic [LEAF_SIZE*DW-1:0]   in_dist;
    logic [LEAF_SIZE*IW-1:0]   in_idx;
    logic                      s1_valid, s1_first, s1_last;
    logic [DW-1:0]             s1_d [K];
    logic [IW-1:0]             s1_i [K];
    logic [DW-1:0]             lst_d [K];
    logic [IW-1:0]             lst_i [K];
    logic                      lst_v [K];
    logic                      open;
    logic [QCNT_WIDTH-1:0]     qcnt;
    logic [DW-1:0]             srt_d [K];
    logic [IW-1:0]             srt_i [K];
    logic [DW-1:0]             u_d [N];
    logic [IW-1:0]             u_i [N];
    logic [1:0]                u_c [N];
    logic [DW-1:0]             m_d [K];
    logic [IW-1:0]             m_i [K];
    logic                      m_v [K];
    logic [K*DW-1:0]           m_pd;
    logic [K*IW-1:0]           m_pi;
    int                        r1 [LEAF_SIZE];
    int                        r2 [N];

    // Stable sort by rank: lane i goes to slot = number of lanes ordered before it.
    always_comb begin
        for (int i = 0; i < LEAF_SIZE; i++) begin
            r1[i] = 0;
            for (int j = 0; j < LEAF_SIZE; j++)
                if (in_dist[j*DW+:DW] < in_dist[i*DW+:DW] ||
                    (in_dist[j*DW+:DW] == in_dist[i*DW+:DW] && j < i))
                    r1[i] = r1[i] + 1;
        end
        for (int k = 0; k < K; k++) begin
            srt_d[k] = '0;
            srt_i[k] = '0;
            for (int i = 0; i < LEAF_SIZE; i++)
                if (r1[i] == k) begin
                    srt_d[k] = in_dist[i*DW+:DW];
                    srt_i[k] = in_idx[i*IW+:IW];
                end
        end
    end

    // Tie class on equal distance: real list entry (0) < new candidate (1) < empty slot (2).
    always_comb begin
        for (int k = 0; k < K; k++) begin
            u_d[k] = s1_first ? '1 : lst_d[k];
            u_i[k] = s1_first ? '0 : lst_i[k];
            u_c[k] = (s1_first || !lst_v[k]) ? 2'd2 : 2'd0;
            u_d[K+k] = s1_d[k];
            u_i[K+k] = s1_i[k];
            u_c[K+k] = 2'd1;
        end
        for (int e = 0; e < N; e++) begin
            r2[e] = 0;
            for (int f = 0; f < N; f++)
                if (u_d[f] < u_d[e] || (u_d[f] == u_d[e] &&
                    (u_c[f] < u_c[e] || (u_c[f] == u_c[e] && f < e))))
                    r2[e] = r2[e] + 1;
        end
        for (int k = 0; k < K; k++) begin
            m_d[k] = '1;
            m_i[k] = '0;
            m_v[k] = 1'b0;
            for (int e = 0; e < N; e++)
                if (r2[e] == k) begin
                    m_d[k] = u_d[e];
                    m_i[k] = u_i[e];
                    m_v[k] = u_c[e] != 2'd2;
                end
            m_pd[k*DW+:DW] = m_d[k];
            m_pi[k*IW+:IW] = m_i[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_valid     <= 1'b0;
            in_first     <= 1'b0;
            in_last      <= 1'b0;
            in_dist      <= '0;
            in_idx       <= '0;
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            for (int k = 0; k < K; k++) begin
                s1_d[k]  <= '0;
                s1_i[k]  <= '0;
                lst_d[k] <= '1;
                lst_i[k] <= '0;
                lst_v[k] <= 1'b0;
            end
            open         <= 1'b0;
            qcnt         <= '0;
            result_valid <= 1'b0;
            result_dist  <= '0;
            result_idx   <= '0;
            result_qid   <= '0;
            protocol_err <= 1'b0;
        end else begin
            in_valid     <= dist_valid;
            in_first     <= query_first_in;
            in_last      <= query_last_in;
            in_dist      <= cand_dist;
            in_idx       <= cand_idx;
            s1_valid     <= in_valid;
            s1_first     <= in_first;
            s1_last      <= in_last;
            for (int k = 0; k < K; k++) begin
                s1_d[k] <= srt_d[k];
                s1_i[k] <= srt_i[k];
            end
            result_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                open         <= !s1_last && (s1_first || open);
                protocol_err <= protocol_err || (s1_first == open);
                for (int k = 0; k < K; k++) begin
                    lst_d[k] <= s1_last ? '1 : m_d[k];
                    lst_i[k] <= s1_last ? '0 : m_i[k];
                    lst_v[k] <= !s1_last && m_v[k];
                end
                if (s1_last) begin
                    result_dist <= m_pd;
                    result_idx  <= m_pi;
                    result_qid  <= qcnt;
                    qcnt        <= qcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_knn_topk_merger.sv
// tb_knn_topk_merger: directed and randomized beats checked against a queue-based
// top-K model; every cycle compares result outputs with the model's expectation.
module tb_knn_topk_merger;
    localparam int DW = 25;
    localparam int IW = 9;
    localparam int L = 8;
    localparam int K = 4;
    localparam int QW = 9;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } ent_t;
    typedef struct {
        int            due;
        logic [K*DW-1:0] d;
        logic [K*IW-1:0] i;
        logic [QW-1:0]   q;
    } res_t;

    logic clk = 0, rst_n = 0, dist_valid = 0, query_first_in = 0, query_last_in = 0;
    logic [L*DW-1:0] cand_dist = '0;
    logic [L*IW-1:0] cand_idx = '0;
    logic result_valid, protocol_err;
    logic [K*DW-1:0] result_dist;
    logic [K*IW-1:0] result_idx;
    logic [QW-1:0] result_qid;

    knn_topk_merger #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .LEAF_SIZE(L), .K(K), .QCNT_WIDTH(QW)) dut (
        .clk(clk), .rst_n(rst_n), .dist_valid(dist_valid), .query_first_in(query_first_in),
        .query_last_in(query_last_in), .cand_dist(cand_dist), .cand_idx(cand_idx),
        .result_valid(result_valid), .result_dist(result_dist), .result_idx(result_idx),
        .result_qid(result_qid), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    ent_t lst[$], work[$];
    res_t pend[$];
    bit m_open = 0, m_err = 0;
    logic [QW-1:0] m_qcnt = '0;
    logic [K*DW-1:0] h_d = '0;
    logic [K*IW-1:0] h_i = '0;
    logic [QW-1:0] h_q = '0;
    logic [DW-1:0] bd [L];
    logic [IW-1:0] bi [L];

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Insert keeping ascending order; equal distances go behind existing entries.
    task automatic ins(ent_t e);
        int p = 0;
        while (p < work.size() && work[p].d <= e.d) p++;
        work.insert(p, e);
    endtask

    task automatic model_beat(bit f, bit l);
        ent_t nw[$];
        res_t r;
        if ((f && m_open) || (!f && !m_open)) m_err = 1;
        if (f) lst.delete();
        work.delete();
        for (int n = 0; n < L; n++) ins('{d: bd[n], i: bi[n]});
        nw = work[0:K-1];
        work = lst;
        foreach (nw[n]) ins(nw[n]);
        while (work.size() > K) void'(work.pop_back());
        lst = work;
        if (l) begin
            r.due = cyc + 3;
            r.q = m_qcnt;
            for (int k = 0; k < K; k++) begin
                r.d[k*DW+:DW] = k < lst.size() ? lst[k].d : '1;
                r.i[k*IW+:IW] = k < lst.size() ? lst[k].i : '0;
            end
            pend.push_back(r);
            m_qcnt++;
            lst.delete();
        end
        m_open = l ? 0 : (f ? 1 : m_open);
    endtask

    task automatic step(bit v, bit f, bit l);
        bit ev;
        res_t r;
        dist_valid = v;
        query_first_in = f;
        query_last_in = l;
        for (int n = 0; n < L; n++) begin
            cand_dist[n*DW+:DW] = bd[n];
            cand_idx[n*IW+:IW] = bi[n];
        end
        if (v) model_beat(f, l);
        @(posedge clk);
        #1;
        cyc++;
        ev = pend.size() > 0 && pend[0].due == cyc;
        if (ev) begin
            r = pend.pop_front();
            h_d = r.d;
            h_i = r.i;
            h_q = r.q;
        end
        chk("result_valid", 128'(result_valid), 128'(ev));
        chk("result_dist", 128'(result_dist), 128'(h_d));
        chk("result_idx", 128'(result_idx), 128'(h_i));
        chk("result_qid", 128'(result_qid), 128'(h_q));
    endtask

    task automatic drain();
        repeat (4) step(0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        dist_valid = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1;
        pend.delete();
        lst.delete();
        m_open = 0;
        m_err = 0;
        m_qcnt = '0;
        h_d = '0;
        h_i = '0;
        h_q = '0;
    endtask

    function automatic logic [DW-1:0] rd();
        int m = $urandom_range(0, 9);
        return m < 5 ? DW'($urandom_range(0, 20)) : (m < 9 ? DW'($urandom) : '1);
    endfunction

    task automatic rand_beat();
        for (int n = 0; n < L; n++) begin
            bd[n] = rd();
            bi[n] = IW'($urandom);
        end
    endtask

    initial begin
        for (int n = 0; n < L; n++) begin
            bd[n] = '0;
            bi[n] = '0;
        end
        repeat (2) @(posedge clk);
        do_reset();
        chk("reset_err", 128'(protocol_err), 128'(0));
        step(0, 0, 0);

        // Single-leaf query with a distance tie
        bd = '{50, 10, 90, 10, 70, 5, 200, 30};
        for (int n = 0; n < L; n++) bi[n] = IW'(100 + n);
        step(1, 1, 1);
        drain();
        chk("t1_dist", 128'(result_dist), 128'({25'd30, 25'd10, 25'd10, 25'd5}));
        chk("t1_idx", 128'(result_idx), 128'({9'd107, 9'd103, 9'd101, 9'd105}));
        chk("t1_qid", 128'(result_qid), 128'(0));

        // Three-beat query
        for (int n = 0; n < L; n++) begin bd[n] = DW'(40 + n); bi[n] = IW'(n); end
        step(1, 1, 0);
        bd = '{100, 3, 7, 101, 102, 103, 104, 105};
        for (int n = 0; n < L; n++) bi[n] = IW'(16 + n);
        step(1, 0, 0);
        bd = '{1, 110, 111, 112, 113, 114, 115, 116};
        for (int n = 0; n < L; n++) bi[n] = IW'(32 + n);
        step(1, 0, 1);
        drain();
        chk("t2_dist", 128'(result_dist), 128'({25'd40, 25'd7, 25'd3, 25'd1}));

        // Existing entry wins an equal-distance tie
        for (int n = 0; n < L; n++) begin bd[n] = DW'(49 + n); bi[n] = IW'(n); end
        bd[0] = 7;
        step(1, 1, 0);
        for (int n = 0; n < L; n++) begin bd[n] = DW'(200 + n); bi[n] = IW'(100 + n); end
        bd[4] = 7;
        step(1, 0, 1);
        drain();
        chk("t2_tie_idx", 128'(result_idx), 128'({9'd2, 9'd1, 9'd104, 9'd0}));

        // All-ones candidates beat empty slots
        for (int n = 0; n < L; n++) begin bd[n] = '1; bi[n] = IW'(200 + n); end
        step(1, 1, 1);
        drain();
        chk("ones_idx", 128'(result_idx), 128'({9'd203, 9'd202, 9'd201, 9'd200}));

        // Back-to-back queries and qid wrap
        do_reset();
        for (int q = 0; q < 513; q++) begin
            rand_beat();
            step(1, 1, 1);
        end
        drain();
        chk("wrap_qid", 128'(result_qid), 128'(0));

        // Idle beats inside a query carry ignored flags
        rand_beat();
        step(1, 1, 0);
        repeat (5) begin rand_beat(); step(0, 0, 1); end
        rand_beat();
        step(1, 0, 1);
        drain();
        chk("gap_err", 128'(protocol_err), 128'(0));

        // first, first, last
        do_reset();
        rand_beat(); step(1, 1, 0);
        rand_beat(); step(1, 1, 0);
        rand_beat(); step(1, 0, 1);
        drain();
        chk("ff_err", 128'(protocol_err), 128'(1));
        chk("ff_qid", 128'(result_qid), 128'(0));

        // Continuation beat with no open query
        do_reset();
        rand_beat(); step(1, 0, 1);
        drain();
        chk("orphan_err", 128'(protocol_err), 128'(m_err));
        chk("orphan_err_set", 128'(protocol_err), 128'(1));

        // Reset mid-query drops it
        do_reset();
        rand_beat(); step(1, 1, 0);
        do_reset();
        drain();
        rand_beat(); step(1, 1, 1);
        drain();
        chk("rst_qid", 128'(result_qid), 128'(0));
        chk("rst_err", 128'(protocol_err), 128'(0));

        // Randomized well-formed queries with gaps
        for (int q = 0; q < 60; q++) begin
            int len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    rand_beat();
                    step(0, $urandom_range(0, 1), $urandom_range(0, 1));
                end
                rand_beat();
                step(1, b == 0, b == len - 1);
            end
        end
        drain();
        chk("rand_err", 128'(protocol_err), 128'(m_err));
        chk("rand_pending", 128'(pend.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
